am_modulator: RTL and testbench

//  Transmit-side counterpart of the AM receive path: takes signed 8-bit audio samples and produces

---
 rtl/am_pkg.sv | 6 +
 rtl/am_modulator_if.sv | 17 +
 rtl/am_sine_lut.sv | 33 +++
 rtl/am_modulator.sv | 94 +++++++++
 tb/tb_am_modulator.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/am_pkg.sv
// Shared definitions for the AM modulator: FSM state encoding and sine-table geometry.
package am_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ENV, S_MULI, S_MULQ} state_t;
  localparam int SINE_AMP = 127;
  localparam int IDX_W    = 8;
endpackage

// File: rtl/am_modulator_if.sv
// Audio-in / I-Q-out bus of the AM modulator; master is the sample source, slave the modulator.
interface am_modulator_if #(parameter int PHASE_W = 16);
  logic signed [7:0]  d_in;
  logic               d_valid;
  logic [7:0]         mod_index;
  logic [PHASE_W-1:0] tune_word;
  logic signed [7:0]  I_out;
  logic signed [7:0]  Q_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  modport master (output d_in, d_valid, mod_index, tune_word,
                  input  I_out, Q_out, out_valid, busy, overrun);
  modport slave  (input  d_in, d_valid, mod_index, tune_word,
                  output I_out, Q_out, out_valid, busy, overrun);
endinterface

// File: rtl/am_sine_lut.sv
// Combinational sin/cos for an 8-bit phase index, folded from a 64-entry quarter-wave ROM.
module am_sine_lut
  import am_pkg::*;
(
  input  logic [IDX_W-1:0]  k,
  output logic signed [7:0] sin_o,
  output logic signed [7:0] cos_o
);
  // round(127*sin(2*pi*i/256)), i = 0..63
  localparam logic [6:0] QROM [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127};

  // Odd quadrants read the ROM mirrored; the peak (j==0 there) lies just past the table end.
  function automatic logic signed [7:0] fold(input logic [7:0] kk);
    logic [5:0] j;
    logic [6:0] mag;
    j = kk[5:0];
    if (!kk[6])         mag = QROM[j];
    else if (j == 6'd0) mag = 7'(SINE_AMP);
    else                mag = QROM[6'(7'd64 - {1'b0, j})];
    fold = kk[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  assign sin_o = fold(k);
  assign cos_o = fold(8'(k + 8'd64));
endmodule

// File: rtl/am_modulator.sv
// AM modulator: envelope from audio*index, rotated by a per-sample NCO, all products
// through one registered 9x9 signed multiplier sequenced by a 4-state FSM.
module am_modulator
  import am_pkg::*;
#(
  parameter int unsigned CARRIER_LVL = 128,
  parameter int          PHASE_W     = 16
) (
  input logic          clk,
  input logic          rst_n,
  am_modulator_if.slave bus
);
  localparam logic [7:0] CL8 = 8'(CARRIER_LVL);

  state_t               state;
  logic [PHASE_W-1:0]   phase;
  logic [IDX_W-1:0]     ph_k;
  logic [7:0]           env_r;
  logic signed [10:0]   prod_hi;   // product >>> 7; bits [8:1] give product >>> 8
  logic signed [7:0]    i_r, i_q, q_q;
  logic                 vld_q, ovr_q;
  logic signed [8:0]    mul_a, mul_b;
  logic signed [10:0]   env_w;
  logic [7:0]           env_c;
  logic signed [7:0]    sin_v, cos_v;

  am_sine_lut u_lut (.k(ph_k), .sin_o(sin_v), .cos_o(cos_v));

  always_comb begin
    env_w = $signed({3'b000, CL8}) + prod_hi;
    if (env_w < 11'sd0)        env_c = 8'd0;
    else if (env_w > 11'sd255) env_c = 8'd255;
    else                       env_c = env_w[7:0];
  end

  // Multiplier operand select: audio*index, then env*cos, then env*sin.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_IDLE: begin mul_a = {bus.d_in[7], bus.d_in}; mul_b = {1'b0, bus.mod_index}; end
      S_ENV:  begin mul_a = {1'b0, env_c};           mul_b = {cos_v[7], cos_v};     end
      S_MULI: begin mul_a = {1'b0, env_r};           mul_b = {sin_v[7], sin_v};     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      ph_k    <= '0;
      env_r   <= '0;
      prod_hi <= '0;
      i_r     <= '0;
      i_q     <= '0;
      q_q     <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prod_hi <= 11'((18'(mul_a) * 18'(mul_b)) >>> 7);
      vld_q   <= 1'b0;
      ovr_q   <= bus.d_valid && (state != S_IDLE);
      case (state)
        S_IDLE: if (bus.d_valid) begin
          ph_k  <= phase[PHASE_W-1 -: IDX_W];
          phase <= phase + bus.tune_word;
          state <= S_ENV;
        end
        S_ENV: begin
          env_r <= env_c;
          state <= S_MULI;
        end
        S_MULI: begin
          i_r   <= prod_hi[8:1];
          state <= S_MULQ;
        end
        S_MULQ: begin
          i_q   <= i_r;
          q_q   <= prod_hi[8:1];
          vld_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.I_out     = i_q;
  assign bus.Q_out     = q_q;
  assign bus.out_valid = vld_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_am_modulator.sv
// Bench for am_modulator: directed corner cases plus random traffic against a transaction-level model.
module tb_am_modulator;
  localparam int PHASE_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  am_modulator_if #(.PHASE_W(PHASE_W)) bus();

  am_modulator #(.CARRIER_LVL(128), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; int i; int q;} out_t;
  out_t pend[$];
  int   ph, busy_cnt, exp_i, exp_q, cyc;
  bit   ovr_next;

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic int ref_sin(input int k);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic void model_iq(input int d, input int idx, input int k,
                                   output int i, output int q);
    int env;
    env = 128 + fdiv(d * idx, 128);
    if (env < 0)   env = 0;
    if (env > 255) env = 255;
    i = fdiv(env * ref_sin((k + 64) % 256), 256);
    q = fdiv(env * ref_sin(k), 256);
  endfunction

  task automatic model_reset();
    pend.delete();
    ph = 0; busy_cnt = 0; exp_i = 0; exp_q = 0; ovr_next = 0;
  endtask

  // One clock: check this cycle's outputs, then drive this cycle's inputs.
  task automatic step(input bit dv, input int d, input int idx, input int tune);
    bit ev;
    int i, q;
    @(posedge clk); #1;
    cyc++;
    ev = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1; exp_i = pend[0].i; exp_q = pend[0].q;
      void'(pend.pop_front());
    end
    chk($sformatf("out_valid@%0d", cyc), int'(bus.out_valid), int'(ev));
    chk($sformatf("I_out@%0d", cyc), bus.I_out, exp_i);
    chk($sformatf("Q_out@%0d", cyc), bus.Q_out, exp_q);
    chk($sformatf("busy@%0d", cyc), int'(bus.busy), int'(busy_cnt > 0));
    chk($sformatf("overrun@%0d", cyc), int'(bus.overrun), int'(ovr_next));
    ovr_next = 0;
    bus.d_valid   = dv;
    bus.d_in      = 8'(d);
    bus.mod_index = 8'(idx);
    bus.tune_word = 16'(tune);
    if (dv && busy_cnt == 0) begin
      model_iq(d, idx, ph / 256, i, q);
      pend.push_back('{cyc + 4, i, q});
      ph = (ph + tune) % 65536;
      busy_cnt = 3;
    end else begin
      if (dv) ovr_next = 1;
      if (busy_cnt > 0) busy_cnt--;
    end
  endtask

  task automatic send(input int d, input int idx, input int tune,
                      input int ei, input int eq, input string tag);
    step(1, d, idx, tune);
    repeat (4) step(0, 0, 0, 0);
    chk({tag, "_I"}, bus.I_out, ei);
    chk({tag, "_Q"}, bus.Q_out, eq);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_I"}, bus.I_out, 0);
    chk({tag, "_Q"}, bus.Q_out, 0);
    chk({tag, "_vld"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_ovr"}, int'(bus.overrun), 0);
  endtask

  initial begin
    bus.d_valid = 0; bus.d_in = 0; bus.mod_index = 0; bus.tune_word = 0;
    cyc = 0;
    model_reset();
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // carrier only, full modulation extremes, overmodulation clamps
    send(0, 128, 0, 63, 0, "carrier");
    send(127, 128, 0, 126, 0, "pos_peak");
    send(-128, 128, 0, 0, 0, "neg_peak");
    send(-128, 255, 0, 0, 0, "ovm_low");
    send(127, 255, 0, 126, 0, "ovm_high");

    // NCO quarter turns, wrap to phase 0 on the fifth sample
    send(0, 128, 16'h4000, 63, 0, "nco0");
    send(0, 128, 16'h4000, 0, 63, "nco1");
    send(0, 128, 16'h4000, -64, 0, "nco2");
    send(0, 128, 16'h4000, 0, -64, "nco3");
    send(0, 128, 16'h4000, 63, 0, "nco4");

    // back-to-back strobes: second dropped, phase advanced once (now 0x4000 -> 0x8000)
    step(1, 0, 128, 16'h4000);
    step(1, 0, 128, 16'h4000);
    repeat (3) step(0, 0, 0, 0);
    chk("ovr_pair_I", bus.I_out, 0);
    chk("ovr_pair_Q", bus.Q_out, 63);
    send(0, 128, 0, -64, 0, "after_ovr");

    // strobe in the S_MULQ cycle is dropped too
    step(1, 50, 100, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 10, 10, 16'h1234);
    repeat (3) step(0, 0, 0, 0);

    // reset while in S_MULI: outputs clear at once, sample lost, phase restarts at 0
    step(1, 127, 128, 16'h2000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    bus.d_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step(0, 0, 0, 0);
    send(0, 128, 16'h4000, 63, 0, "post_rst");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)));
    end
    repeat (6) step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
